nip_window_3x3: RTL and testbench
=================================

NIP_WINDOW_3X3 -- requirements
Module: nip_window_3x3

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL provide parameter IMG_W, default 16, pixels per line (legal range 3..1024).
REQ-003 SHALL provide parameter IMG_H, default 16, lines per frame (legal range 3..1024).
REQ-004 SHALL have port clk_in1  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_valid  input  1  input pixel valid.
REQ-007 SHALL have port s_ready  output  1  input pixel accepted when s_valid and s_ready are both high.
REQ-008 SHALL have port s_data  input  DATA_W  input pixel, raster order, left to right, top to bottom.
REQ-009 SHALL have port m_valid  output  1  window valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts the window when m_valid and m_ready are both high.
REQ-011 SHALL have port m_window  output  9*DATA_W  3x3 window; slice k = [k*DATA_W +: DATA_W], k = 3*r + c, r = 0 is the top row, c = 0 is the left column.
REQ-012 SHALL have port m_x  output  10  window centre column.
REQ-013 SHALL have port m_y  output  10  window centre row.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse marking the acceptance of the last pixel of a frame.

Function
REQ-015 SHALL track the accepted pixel position with a column counter col (0..IMG_W-1) and a row counter row (0..IMG_H-1); both SHALL advance only on an input handshake.
REQ-016 SHALL wrap col from IMG_W-1 to 0 and increment row; at row=IMG_H-1 and col=IMG_W-1, both SHALL wrap to 0.
REQ-017 SHALL hold two line buffers of IMG_W entries containing lines row-1 and row-2; on each handshake, column col SHALL be shifted (line1 to line2, s_data to line1).
REQ-018 SHALL keep a 3-column shift window of (line2[col], line1[col], s_data), shifted on each handshake.
REQ-019 SHALL emit a window only for accepted pixels with row>=2 and col>=2 (interior only, no padding); this gives (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-020 SHALL present the window in the cycle after the accepting handshake (latency 1), with m_x=col-1 and m_y=row-1 of that pixel.
REQ-021 SHALL hold m_valid, m_window, m_x and m_y stable while m_valid=1 and m_ready=0.
REQ-022 SHALL drive s_ready = !rst && (!m_valid || m_ready), so that no window is ever dropped or overwritten.
REQ-023 SHALL load a new window in the same cycle that the old one is consumed when both handshakes occur together; m_valid SHALL then stay 1.
REQ-024 SHALL clear m_valid after a consumption that has no new qualifying pixel.
REQ-025 SHALL pulse frame_done exactly one cycle after the handshake of pixel (IMG_W-1, IMG_H-1), whatever the state of m_ready.
REQ-026 SHALL start a new frame with the next pixel after the frame wrap; stale line-buffer contents SHALL never appear, because rows 0-1 produce no window.
REQ-027 SHALL ignore s_data whenever s_valid=0, and SHALL keep all state unchanged in such cycles.

Reset
REQ-028 SHALL, while rst=1, set col=0, row=0, m_valid=0, m_window=0, m_x=0, m_y=0, frame_done=0 and s_ready=0.
REQ-029 SHALL leave line-buffer contents undefined after reset; no output SHALL depend on them before they are rewritten.
REQ-030 SHALL treat reset in mid-frame as abandoning the frame: the first pixel after reset is pixel (0,0) and any pending window is lost.

Verification (IMG_W=4, IMG_H=4, DATA_W=8)
REQ-031 SHALL cover: pixels 0..15 streamed with m_ready=1 -> exactly 4 windows; the first arrives one cycle after pixel 10 with slices 0..8 = 0,1,2,4,5,6,8,9,10 at (m_x,m_y)=(1,1); the last = 5,6,7,9,10,11,13,14,15 at (2,2).
REQ-032 SHALL cover: the same stream with m_ready held low from pixel 10 -> s_ready drops after pixel 10 is accepted, the window holds stable, pixel 11 is not accepted until m_ready=1, and the window sequence is unchanged.
REQ-033 SHALL cover: random s_valid/m_ready gaps (50%) over 3 back-to-back frames -> 12 windows, each matching a software 3x3 reference, and exactly 3 frame_done pulses.
REQ-034 SHALL cover: rst asserted for one cycle after pixel 9 -> m_valid=0 and s_ready=0 during reset; a restarted frame 100..115 then gives a first window of 100,101,102,104,105,106,108,109,110.
REQ-035 SHALL cover: a frame ending while a window is stalled -> frame_done pulses once, and the next frame's pixel 0 is accepted only after the window is consumed.

Source files
------------

// File: rtl/nip_window_3x3.sv
// nip_window_3x3: streaming 3x3 neighbourhood extractor for raster-order pixels.
// Two line buffers hold the previous two lines. A two-column shift window holds
// the left part of the neighbourhood. A window is emitted only for interior
// pixels, with one cycle of latency and a single-entry output register that
// holds its contents while backpressured.
//
// Ports:
//   clk_in1     rising-edge clock
//   rst         synchronous active-high reset
//   s_valid     input pixel valid
//   s_ready     input pixel accepted when s_valid && s_ready (combinational)
//   s_data      input pixel, raster order
//   m_valid     output window valid
//   m_ready     downstream accepts the window when m_valid && m_ready
//   m_window    3x3 window, slice k = 3*r + c (r=0 top row, c=0 left column)
//   m_x, m_y    window centre column / row
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
module nip_window_3x3 #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IMG_W  = 16,
   parameter int unsigned IMG_H  = 16
) (
   input  logic                clk_in1,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_W-1:0]   s_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [9*DATA_W-1:0] m_window,
   output logic [9:0]          m_x,
   output logic [9:0]          m_y,
   output logic                frame_done
);

   localparam int unsigned CNT_W = 10;
   localparam int unsigned AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned COL_W = 3 * DATA_W;
   localparam int unsigned WIN_W = 9 * DATA_W;

   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic             m_valid_q, m_valid_d;
   logic [WIN_W-1:0] m_window_q, m_window_d;
   logic [CNT_W-1:0] m_x_q, m_x_d;
   logic [CNT_W-1:0] m_y_q, m_y_d;
   logic             frame_done_q, frame_done_d;

   // Line buffers: line1 holds row-1, line2 holds row-2 (contents undefined after reset).
   logic [DATA_W-1:0] line1_q [IMG_W];
   logic [DATA_W-1:0] line2_q [IMG_W];

   // Shift window columns, packed with the top row at offset 0.
   logic [COL_W-1:0] sh0_q;
   logic [COL_W-1:0] sh1_q;

   logic             accept;
   logic             emit;
   logic             last_col;
   logic             last_row;
   logic [AW-1:0]    idx;
   logic [COL_W-1:0] new_col;
   logic [WIN_W-1:0] win;

   // No window can be dropped: the single output slot must be empty or draining.
   assign s_ready = !rst && (!m_valid_q || m_ready);
   assign accept  = s_valid && s_ready;
   assign idx     = col_q[AW-1:0];

   // Counter advance, window assembly and output-slot next state.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      m_valid_d    = m_valid_q;
      m_window_d   = m_window_q;
      m_x_d        = m_x_q;
      m_y_d        = m_y_q;
      frame_done_d = 1'b0;
      win          = '0;

      last_col = (col_q == CNT_W'(IMG_W - 1));
      last_row = (row_q == CNT_W'(IMG_H - 1));
      new_col  = {s_data, line1_q[idx], line2_q[idx]};

      for (int r = 0; r < 3; r++) begin
         win[(3*r + 0)*DATA_W +: DATA_W] = sh0_q[r*DATA_W +: DATA_W];
         win[(3*r + 1)*DATA_W +: DATA_W] = sh1_q[r*DATA_W +: DATA_W];
         win[(3*r + 2)*DATA_W +: DATA_W] = new_col[r*DATA_W +: DATA_W];
      end

      // Rows 0-1 and columns 0-1 never emit, so stale buffer data never escapes.
      emit = accept && (row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2));

      if (accept) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + CNT_W'(1);
         end else begin
            col_d = col_q + CNT_W'(1);
         end
         frame_done_d = last_col && last_row;
      end

      if (emit) begin
         m_valid_d  = 1'b1;
         m_window_d = win;
         m_x_d      = col_q - CNT_W'(1);
         m_y_d      = row_q - CNT_W'(1);
      end else if (m_ready) begin
         m_valid_d  = 1'b0;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk_in1) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         m_valid_q    <= 1'b0;
         m_window_q   <= '0;
         m_x_q        <= '0;
         m_y_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         m_valid_q    <= m_valid_d;
         m_window_q   <= m_window_d;
         m_x_q        <= m_x_d;
         m_y_q        <= m_y_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffers and shift window; accept is already low during reset.
   always_ff @(posedge clk_in1) begin
      if (accept) begin
         line2_q[idx] <= line1_q[idx];
         line1_q[idx] <= s_data;
         sh0_q        <= sh1_q;
         sh1_q        <= new_col;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_window   = m_window_q;
   assign m_x        = m_x_q;
   assign m_y        = m_y_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nip_window_3x3.sv
// Bench for nip_window_3x3 at 4x4 frames, 8-bit pixels. A model records every
// accepted pixel into an image array and derives each expected window directly
// from that image.
module tb_nip_window_3x3;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [9*DW-1:0] m_window;
   logic [9:0]    m_x;
   logic [9:0]    m_y;
   logic          frame_done;

   always #5 clk = ~clk;

   nip_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk_in1    (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_window   (m_window),
      .m_x        (m_x),
      .m_y        (m_y),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [71:0] w;
      logic [9:0]  x;
      logic [9:0]  y;
   } win_t;

   win_t        exp_q[$];
   int          img[H][W];
   int          px, py;
   logic        exp_fd;
   int          checks, failures;
   int          win_cnt, fd_cnt;
   logic        first_seen;
   logic [71:0] first_w, last_w;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Window whose pixel at (r,c) is base + W*r + c.
   function automatic logic [71:0] seq_win(input int base);
      logic [71:0] w;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[(3*r + c)*8 +: 8] = 8'(base + W*r + c);
      return w;
   endfunction

   // Model: store the pixel at its raster position; interior pixels yield a window.
   task automatic model_push(input logic [7:0] d);
      win_t e;
      img[py][px] = int'(d);
      if (px >= 2 && py >= 2) begin
         e.w = '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               e.w[(3*r + c)*8 +: 8] = 8'(img[py-2+r][px-2+c]);
         e.x = 10'(px - 1);
         e.y = 10'(py - 1);
         exp_q.push_back(e);
      end
      if (px == W-1 && py == H-1) exp_fd = 1'b1;
      px++;
      if (px == W) begin
         px = 0;
         py = (py == H-1) ? 0 : py + 1;
      end
   endtask

   // One clock cycle: drive, check every observable output, update the model.
   task automatic cyc(input logic sv, input logic [7:0] sd, input logic mr, output logic acc);
      win_t f;
      @(negedge clk);
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      #1;
      chk("frame_done", 72'(frame_done), 72'(exp_fd));
      if (frame_done === 1'b1) fd_cnt++;
      chk("m_valid", 72'(m_valid), 72'(exp_q.size() != 0));
      chk("s_ready", 72'(s_ready), 72'((exp_q.size() == 0) || mr));
      if (m_valid === 1'b1 && exp_q.size() != 0) begin
         f = exp_q[0];
         chk("m_window", m_window, f.w);
         chk("m_x", 72'(m_x), 72'(f.x));
         chk("m_y", 72'(m_y), 72'(f.y));
         if (mr) begin
            void'(exp_q.pop_front());
            win_cnt++;
            last_w = m_window;
            if (!first_seen) begin
               first_seen = 1'b1;
               first_w    = m_window;
            end
         end
      end
      acc    = sv && (s_ready === 1'b1);
      exp_fd = 1'b0;
      if (acc) model_push(sd);
      @(posedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic mr);
      logic a;
      int   n;
      a = 1'b0;
      n = 0;
      while (!a && n < 50) begin
         cyc(1'b1, d, mr, a);
         n++;
      end
      if (!a) chk("send_timeout", 72'(a), 72'(1));
   endtask

   task automatic drain(input int n);
      logic a;
      repeat (n) cyc(1'b0, 8'h00, 1'b1, a);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst     = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hAA;
      m_ready = 1'b0;
      #1;
      chk("rst_s_ready", 72'(s_ready), 72'(0));
      repeat (n) begin
         @(posedge clk);
         #1;
         chk("rst_m_valid", 72'(m_valid), 72'(0));
         chk("rst_s_ready", 72'(s_ready), 72'(0));
         chk("rst_m_window", m_window, 72'(0));
         chk("rst_m_xy", 72'({m_x, m_y}), 72'(0));
         chk("rst_frame_done", 72'(frame_done), 72'(0));
      end
      @(negedge clk);
      rst     = 1'b0;
      s_valid = 1'b0;
      exp_q.delete();
      px     = 0;
      py     = 0;
      exp_fd = 1'b0;
   endtask

   task automatic new_test();
      win_cnt    = 0;
      fd_cnt     = 0;
      first_seen = 1'b0;
      first_w    = '0;
      last_w     = '0;
   endtask

   initial begin
      logic a;
      logic sv, mr;
      int   n;
      logic [7:0] d;

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      m_ready  = 1'b0;
      px       = 0;
      py       = 0;
      exp_fd   = 1'b0;
      new_test();
      do_reset(2);

      // Plain stream 0..15 with the sink always ready.
      new_test();
      for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
      drain(3);
      chk("A_win_cnt", 72'(win_cnt), 72'(4));
      chk("A_first_win", first_w, seq_win(0));
      chk("A_last_win", last_w, seq_win(5));
      chk("A_fd_cnt", 72'(fd_cnt), 72'(1));

      // Sink stalls from pixel 10; pixel 11 must wait.
      new_test();
      for (int i = 0; i < 11; i++) send(8'(i), 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'd11, 1'b0, a);
         chk("B_stall_noacc", 72'(a), 72'(0));
      end
      for (int i = 11; i < 16; i++) send(8'(i), 1'b1);
      drain(3);
      chk("B_win_cnt", 72'(win_cnt), 72'(4));
      chk("B_first_win", first_w, seq_win(0));
      chk("B_last_win", last_w, seq_win(5));

      // Three frames of random data with random gaps on both sides.
      new_test();
      for (int i = 0; i < 3*W*H; i++) begin
         d = 8'($urandom);
         a = 1'b0;
         n = 0;
         while (!a && n < 200) begin
            sv = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            cyc(sv, d, mr, a);
            n++;
         end
         if (!a) chk("C_timeout", 72'(a), 72'(1));
      end
      drain(3);
      chk("C_win_cnt", 72'(win_cnt), 72'(12));
      chk("C_fd_cnt", 72'(fd_cnt), 72'(3));

      // Mid-frame reset, then a fresh frame 100..115.
      new_test();
      for (int i = 0; i < 10; i++) send(8'(i), 1'b1);
      do_reset(1);
      for (int i = 100; i < 116; i++) send(8'(i), 1'b1);
      drain(3);
      chk("D_win_cnt", 72'(win_cnt), 72'(4));
      chk("D_first_win", first_w, seq_win(100));
      chk("D_last_win", last_w, seq_win(105));

      // Frame ends while its last window is stalled.
      new_test();
      for (int i = 0; i < 15; i++) send(8'(i + 50), 1'b1);
      drain(2);
      send(8'd65, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'd200, 1'b0, a);
         chk("E_stall_noacc", 72'(a), 72'(0));
      end
      send(8'd200, 1'b1);
      drain(3);
      chk("E_fd_cnt", 72'(fd_cnt), 72'(1));
      chk("E_win_cnt", 72'(win_cnt), 72'(4));
      chk("E_last_win", last_w, seq_win(55));
      chk("E_queue_empty", 72'(exp_q.size()), 72'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
